// File: rtl/parking_occupancy_tracker.sv
// Debounced parking-slot occupancy map with counts, free-slot search and arrival/departure events.
// Each sensor bit must disagree with the committed map for DEBOUNCE enabled samples before it is committed.
module parking_occupancy_tracker #(
    parameter int SLOTS    = 8,
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 4,
    parameter int IDX_W    = 3,
    parameter int TOTAL_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [SLOTS-1:0]   sensor,
    output logic [SLOTS-1:0]   occupancy,
    output logic [CNT_W-1:0]   parked,
    output logic [CNT_W-1:0]   empty,
    output logic               full,
    output logic               vacant,
    output logic [IDX_W-1:0]   first_free,
    output logic               free_valid,
    output logic               arrived,
    output logic               departed,
    output logic               changed,
    output logic [TOTAL_W-1:0] total_entries
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [TOTAL_W:0] TOT_MAX = {1'b0, {TOTAL_W{1'b1}}};

    logic [SLOTS-1:0]   occ_q, occ_d;
    logic [SLOTS-1:0]   rise, fall;
    logic [DB_W-1:0]    cnt_q [SLOTS];
    logic [DB_W-1:0]    cnt_d [SLOTS];
    logic               arrived_q, departed_q;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [CNT_W-1:0]   n_rise;
    logic [TOTAL_W:0]   total_sum;
    logic [CNT_W-1:0]   parked_c;
    logic [IDX_W-1:0]   first_free_c;

    // Per-slot debounce: a sample equal to the committed bit restarts the run.
    always_comb begin
        occ_d = occ_q;
        rise  = '0;
        fall  = '0;
        for (int i = 0; i < SLOTS; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (enable) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (sensor[i] == occ_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    occ_d[i] = sensor[i];
                    cnt_d[i] = '0;
                    rise[i]  = sensor[i];
                    fall[i]  = ~sensor[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Lifetime entry counter adds every rising commit on the edge and saturates.
    always_comb begin
        n_rise = '0;
        for (int i = 0; i < SLOTS; i++) begin
            n_rise = n_rise + CNT_W'(rise[i]);
        end
        total_sum = {1'b0, total_q} + (TOTAL_W + 1)'(n_rise);
        total_d   = (total_sum > TOT_MAX) ? TOT_MAX[TOTAL_W-1:0] : total_sum[TOTAL_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q      <= '0;
            arrived_q  <= 1'b0;
            departed_q <= 1'b0;
            total_q    <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            occ_q      <= occ_d;
            arrived_q  <= |rise;
            departed_q <= |fall;
            total_q    <= total_d;
            for (int i = 0; i < SLOTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Status outputs are decoded straight from the committed map, no extra latency.
    always_comb begin
        parked_c     = '0;
        first_free_c = '0;
        for (int i = 0; i < SLOTS; i++) begin
            parked_c = parked_c + CNT_W'(occ_q[i]);
        end
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                first_free_c = IDX_W'(i);
            end
        end
    end

    assign occupancy     = occ_q;
    assign parked        = parked_c;
    assign empty         = CNT_W'(SLOTS) - parked_c;
    assign full          = (parked_c == CNT_W'(SLOTS));
    assign vacant        = (parked_c == '0);
    assign first_free    = first_free_c;
    assign free_valid    = ~full;
    assign arrived       = arrived_q;
    assign departed      = departed_q;
    assign changed       = arrived_q | departed_q;
    assign total_entries = total_q;

endmodule
